// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM state type and counter sizing for serial_sub
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_sub.sv
// rtl/full_sub.sv - single-bit full subtractor cell: d = a - b - c, bo = borrow out
module full_sub (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ c;
  assign bo = (~a & b) | (~a & c) | (b & c);

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first subtractor a - b - bin around one full_sub cell
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             fs_d;
  logic             fs_bo;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  full_sub u_fs (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .c  (brw),
    .d  (fs_d),
    .bo (fs_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (last_bit) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // After the final RUN edge brw holds the borrow out of the MSB, so it doubles as bout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
    end else if (state == ST_IDLE && in_valid) begin
      a_sr <= a;
      b_sr <= b;
      brw  <= bin;
      cnt  <= '0;
    end else if (state == ST_RUN) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      diff_sr <= {fs_d, diff_sr[WIDTH-1:1]};
      brw     <= fs_bo;
      cnt     <= cnt + CW'(1);
    end
  end

  assign diff = diff_sr;
  assign bout = brw;

`ifdef SERIAL_SUB_OVF_EN
  logic msb_brw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         msb_brw <= 1'b0;
    else if (state == ST_RUN && last_bit) msb_brw <= brw;
  end

  assign ovf = msb_brw ^ brw;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed and random self-checking bench for serial_sub (WIDTH=8)
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
  logic       last_ovf;
`endif

  int pass_cnt = 0;
  int total    = 0;

  serial_sub #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input bit stall, output logic [7:0] d, output logic bo,
                        output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (stall) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; lat++;
    end
    d  = diff;
    bo = bout;
`ifdef SERIAL_SUB_OVF_EN
    last_ovf = ovf;
`endif
    n = 0;
    while (out_valid && n < 200) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    total++; if ({bout, diff} !== 9'h000) $display("FAIL reset_data got=%h exp=000", {bout, diff}); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo; int lat;
    run_op(8'h05, 8'h03, 1'b0, 1'b0, d, bo, lat);
    total++; if (lat !== 8) $display("FAIL basic_latency got=%0d exp=8", lat); else pass_cnt++;
    total++; if ({bo, d} !== 9'h002) $display("FAIL basic_05_03 got=%h exp=002", {bo, d}); else pass_cnt++;
  endtask

  task automatic test_negative();
    logic [7:0] d; logic bo; int lat;
    run_op(8'h03, 8'h05, 1'b0, 1'b0, d, bo, lat);
    total++; if ({bo, d} !== 9'h1FE) $display("FAIL neg_03_05 got=%h exp=1fe", {bo, d}); else pass_cnt++;
    run_op(8'h00, 8'h00, 1'b1, 1'b0, d, bo, lat);
    total++; if ({bo, d} !== 9'h1FF) $display("FAIL neg_bin got=%h exp=1ff", {bo, d}); else pass_cnt++;
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, d, bo, lat);
    total++; if ({bo, d} !== 9'h000) $display("FAIL ff_ff got=%h exp=000", {bo, d}); else pass_cnt++;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [7:0] d; logic bo; int lat;
    run_op(8'h80, 8'h01, 1'b0, 1'b0, d, bo, lat);
    total++; if ({last_ovf, bo, d} !== 10'h27F) $display("FAIL ovf_80_01 got=%h exp=27f", {last_ovf, bo, d}); else pass_cnt++;
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, d, bo, lat);
    total++; if ({last_ovf, bo, d} !== 10'h07E) $display("FAIL ovf_7f_01 got=%h exp=07e", {last_ovf, bo, d}); else pass_cnt++;
  endtask
`endif

  task automatic test_backpressure();
    int n;
    bit stable_ok;
    out_ready = 1'b0;
    a = 8'h10; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h20; b = 8'h01;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (n !== 8) $display("FAIL bp_latency got=%0d exp=8", n); else pass_cnt++;
    total++; if ({bout, diff} !== 9'h00F) $display("FAIL bp_first got=%h exp=00f", {bout, diff}); else pass_cnt++;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || {bout, diff} !== 9'h00F) stable_ok = 1'b0;
    end
    total++; if (stable_ok !== 1'b1) $display("FAIL bp_hold got=%b exp=1 data=%h", stable_ok, {bout, diff}); else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_idle got=%b exp=10", {in_ready, out_valid}); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    total++; if ({bout, diff} !== 9'h01F) $display("FAIL bp_second got=%h exp=01f", {bout, diff}); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] d; logic bo; int lat;
    while (!in_ready) begin @(posedge clk); #1; end
    a = 8'hC3; b = 8'h11; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; #1;
    total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL rst_mid_hs got=%b exp=10", {in_ready, out_valid}); else pass_cnt++;
    total++; if ({bout, diff} !== 9'h000) $display("FAIL rst_mid_data got=%h exp=000", {bout, diff}); else pass_cnt++;
    @(posedge clk); #1; rst = 1'b0;
    run_op(8'hA5, 8'h5A, 1'b0, 1'b0, d, bo, lat);
    total++; if ({bo, d} !== 9'h04B) $display("FAIL rst_mid_next got=%h exp=04b", {bo, d}); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] ta, tb, d; logic tbin, bo; logic [8:0] exp9; int lat;
    for (int i = 0; i < 1000; i++) begin
      ta = 8'($urandom); tb = 8'($urandom); tbin = 1'($urandom);
      exp9 = {1'b0, ta} - {1'b0, tb} - {8'h00, tbin};
      run_op(ta, tb, tbin, 1'b1, d, bo, lat);
      total++;
      if ({bo, d} !== exp9 || lat >= 200)
        $display("FAIL rand_%0d a=%h b=%h bin=%b got=%h exp=%h lat=%0d", i, ta, tb, tbin, {bo, d}, exp9, lat);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
